// File: rtl/mdp3_entry_stream_parser_if.sv
// rtl/mdp3_entry_stream_parser_if.sv - byte-stream input, book-entry output and status bundle for the MDP3 parser

interface mdp3_entry_stream_parser_if #(
    parameter int BUS_BYTES = 8
);
    // packet byte stream, byte 0 of a beat in the top byte lane
    logic                         in_valid;
    logic                         in_ready;
    logic [BUS_BYTES*8-1:0]       in_data;
    logic                         in_sop;
    logic                         in_eop;
    logic [$clog2(BUS_BYTES):0]   in_bytes;

    // decoded book entry towards the order book
    logic                         out_valid;
    logic                         out_ready;
    logic [7:0]                   out_action;
    logic [7:0]                   out_entry_type;
    logic [31:0]                  out_security_id;
    logic [31:0]                  out_rpt_seq;
    logic [7:0]                   out_price_level;
    logic [63:0]                  out_price;
    logic [31:0]                  out_quantity;
    logic [31:0]                  out_num_orders;
    logic [31:0]                  out_msg_seq_num;
    logic                         out_last;

    // status
    logic                         err_valid;
    logic [1:0]                   err_code;
    logic [31:0]                  msg_count;

    modport master (
        output in_valid, in_data, in_sop, in_eop, in_bytes, out_ready,
        input  in_ready, out_valid, out_action, out_entry_type, out_security_id,
               out_rpt_seq, out_price_level, out_price, out_quantity, out_num_orders,
               out_msg_seq_num, out_last, err_valid, err_code, msg_count
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, in_bytes, out_ready,
        output in_ready, out_valid, out_action, out_entry_type, out_security_id,
               out_rpt_seq, out_price_level, out_price, out_quantity, out_num_orders,
               out_msg_seq_num, out_last, err_valid, err_code, msg_count
    );
endinterface

// File: rtl/mdp3_entry_stream_parser.sv
// rtl/mdp3_entry_stream_parser.sv - MDP3 incremental-refresh parser, header decode and per-entry book output

module mdp3_entry_stream_parser #(
    parameter int BUS_BYTES       = 8,
    parameter int MAX_ENTRY_BYTES = 32
) (
    input  logic                      clk,     // clock
    input  logic                      reset,   // async, active-low
    mdp3_entry_stream_parser_if.slave bus      // byte stream in, entries out, status
);
    localparam int ACC_BYTES = MAX_ENTRY_BYTES + BUS_BYTES;
    localparam int CW        = $clog2(ACC_BYTES + 1);
    localparam int HDR_BYTES = 32;
    localparam int MIN_ENTRY = 27;

    localparam logic [1:0] ERR_TRUNC = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;
    localparam logic [1:0] ERR_SOP   = 2'd3;

    typedef enum logic [2:0] {IDLE, HDR, ENTRY, EMIT, SKIP} state_t;

    state_t        state, state_n, eff;
    logic [7:0]    acc   [ACC_BYTES];
    logic [7:0]    acc_n [ACC_BYTES];
    logic [7:0]    m     [ACC_BYTES];
    logic [7:0]    beat  [BUS_BYTES];
    logic [CW-1:0] cnt, cnt_n;
    logic          msg_done, done_n, done_now;
    logic [15:0]   ent_len, ent_len_n, hdr_len;
    logic [7:0]    rem, rem_n;
    logic [31:0]   seq, seq_n, mc_n;
    logic          err_v_n;
    logic [1:0]    err_c_n;
    logic          load_ent, last_n, drop_out;
    logic          ready, take;
    int            beat_n, base, mcnt, cons;

    // msg_done: the eop beat has already been taken, so nothing more will arrive
    // for this message; stall the input until the leftover bytes are resolved.
    assign ready        = reset && (state != EMIT) && !msg_done &&
                          ((int'(cnt) + BUS_BYTES) <= ACC_BYTES);
    assign bus.in_ready = ready;
    assign take         = bus.in_valid && ready;

    always_comb begin
        state_n   = state;
        done_n    = msg_done;
        ent_len_n = ent_len;
        rem_n     = rem;
        seq_n     = seq;
        mc_n      = bus.msg_count;
        err_v_n   = 1'b0;
        err_c_n   = 2'd0;
        load_ent  = 1'b0;
        last_n    = 1'b0;
        drop_out  = 1'b0;
        eff       = state;
        base      = int'(cnt);
        beat_n    = 0;
        cons      = 0;

        for (int j = 0; j < BUS_BYTES; j++)
            beat[j] = bus.in_data[BUS_BYTES*8-1-8*j -: 8];

        if (take) begin
            if (bus.in_eop)
                beat_n = (int'(bus.in_bytes) > BUS_BYTES) ? BUS_BYTES : int'(bus.in_bytes);
            else
                beat_n = BUS_BYTES;
            // A start-of-message beat always restarts header collection from empty.
            if (bus.in_sop) begin
                eff  = HDR;
                base = 0;
                if (state != IDLE) begin
                    err_v_n = 1'b1;
                    err_c_n = ERR_SOP;
                end
            end
        end

        // m: held bytes followed by this cycle's beat, oldest byte at index 0
        for (int i = 0; i < ACC_BYTES; i++)
            m[i] = (i < base) ? acc[i] : 8'h00;
        mcnt = base;
        if (take && (eff == HDR || eff == ENTRY)) begin
            for (int j = 0; j < BUS_BYTES; j++)
                if (j < beat_n && (base + j) < ACC_BYTES)
                    m[base + j] = beat[j];
            mcnt = base + beat_n;
        end
        done_now = msg_done || (take && bus.in_eop);
        hdr_len  = {m[30], m[29]};

        case (eff)
            IDLE: begin
                cons = mcnt;
            end
            HDR: begin
                if (mcnt >= HDR_BYTES) begin
                    seq_n     = {m[3], m[2], m[1], m[0]};
                    ent_len_n = hdr_len;
                    rem_n     = m[31];
                    if (int'(hdr_len) < MIN_ENTRY || int'(hdr_len) > MAX_ENTRY_BYTES) begin
                        if (!err_v_n) begin
                            err_v_n = 1'b1;
                            err_c_n = ERR_LEN;
                        end
                        cons    = mcnt;
                        state_n = done_now ? IDLE : SKIP;
                        done_n  = 1'b0;
                    end else if (m[31] == 8'd0) begin
                        mc_n    = bus.msg_count + 32'd1;
                        cons    = mcnt;
                        state_n = done_now ? IDLE : SKIP;
                        done_n  = 1'b0;
                    end else begin
                        cons    = HDR_BYTES;
                        state_n = ENTRY;
                        done_n  = done_now;
                    end
                end else if (done_now) begin
                    if (!err_v_n) begin
                        err_v_n = 1'b1;
                        err_c_n = ERR_TRUNC;
                    end
                    cons    = mcnt;
                    state_n = IDLE;
                    done_n  = 1'b0;
                end else begin
                    state_n = HDR;
                end
            end
            ENTRY: begin
                // Bytes 27..L-1 of the entry are consumed along with it and never decoded.
                if (mcnt >= int'(ent_len)) begin
                    load_ent = 1'b1;
                    last_n   = (rem == 8'd1);
                    cons     = int'(ent_len);
                    state_n  = EMIT;
                    done_n   = done_now;
                end else if (done_now) begin
                    err_v_n = 1'b1;
                    err_c_n = ERR_TRUNC;
                    cons    = mcnt;
                    state_n = IDLE;
                    done_n  = 1'b0;
                end
            end
            EMIT: begin
                if (bus.out_valid && bus.out_ready) begin
                    drop_out = 1'b1;
                    if (rem == 8'd1) begin
                        mc_n    = bus.msg_count + 32'd1;
                        cons    = mcnt;
                        state_n = msg_done ? IDLE : SKIP;
                        done_n  = 1'b0;
                    end else begin
                        rem_n   = rem - 8'd1;
                        state_n = ENTRY;
                    end
                end
            end
            SKIP: begin
                cons = mcnt;
                if (take && bus.in_eop)
                    state_n = IDLE;
            end
            default: begin
                cons    = mcnt;
                state_n = IDLE;
                done_n  = 1'b0;
            end
        endcase

        cnt_n = CW'(mcnt - cons);
        for (int i = 0; i < ACC_BYTES; i++) begin
            acc_n[i] = 8'h00;
            if ((i + cons) < mcnt && (i + cons) < ACC_BYTES)
                acc_n[i] = m[i + cons];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ACC_BYTES; i++)
                acc[i] <= 8'h00;
            cnt                 <= '0;
            msg_done            <= 1'b0;
            ent_len             <= 16'd0;
            rem                 <= 8'd0;
            seq                 <= 32'd0;
            bus.out_valid       <= 1'b0;
            bus.out_action      <= 8'd0;
            bus.out_entry_type  <= 8'd0;
            bus.out_security_id <= 32'd0;
            bus.out_rpt_seq     <= 32'd0;
            bus.out_price_level <= 8'd0;
            bus.out_price       <= 64'd0;
            bus.out_quantity    <= 32'd0;
            bus.out_num_orders  <= 32'd0;
            bus.out_msg_seq_num <= 32'd0;
            bus.out_last        <= 1'b0;
            bus.err_valid       <= 1'b0;
            bus.err_code        <= 2'd0;
            bus.msg_count       <= 32'd0;
        end else begin
            for (int i = 0; i < ACC_BYTES; i++)
                acc[i] <= acc_n[i];
            cnt           <= cnt_n;
            msg_done      <= done_n;
            ent_len       <= ent_len_n;
            rem           <= rem_n;
            seq           <= seq_n;
            bus.err_valid <= err_v_n;
            bus.err_code  <= err_c_n;
            bus.msg_count <= mc_n;
            // Wire fields are little-endian; concatenate highest byte first.
            if (load_ent) begin
                bus.out_valid       <= 1'b1;
                bus.out_action      <= m[0];
                bus.out_entry_type  <= m[1];
                bus.out_security_id <= {m[5], m[4], m[3], m[2]};
                bus.out_rpt_seq     <= {m[9], m[8], m[7], m[6]};
                bus.out_price_level <= m[10];
                bus.out_price       <= {m[18], m[17], m[16], m[15], m[14], m[13], m[12], m[11]};
                bus.out_quantity    <= {m[22], m[21], m[20], m[19]};
                bus.out_num_orders  <= {m[26], m[25], m[24], m[23]};
                bus.out_msg_seq_num <= seq;
                bus.out_last        <= last_n;
            end else if (drop_out) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
